rnd_sched: RTL

Round-robin scheduler that shares the single pipelined rounder (mask generator plus rounding datapath) between the adder and multiplier result streams. Accepts pre-rounding operands from two requesters over valid/ready, issues at most one operand per cycle into the fixed-latency rounder, and tracks the owner of each in-flight operation. It steers each rounded result into a per-requester result FIFO. Credit accounting guarantees the non-stallable rounder never produces a result with nowhere to land.

---
 rtl/rnd_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rnd_sched.sv
// Round-robin scheduler sharing one fixed-latency rounder between the adder (0) and
// multiplier (1) streams, with owner tagging and per-requester result FIFOs.
module rnd_sched #(
  parameter int OPW   = 78,
  parameter int RESW  = 78,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [2*OPW-1:0]    req_op,
  output logic [1:0]          req_ready,
  output logic                rnd_issue,
  output logic [OPW-1:0]      rnd_op,
  input  logic [RESW-1:0]     rnd_res,
  output logic [1:0]          res_valid,
  output logic [2*RESW-1:0]   res_data,
  input  logic [1:0]          res_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  logic [CW-1:0]   cred [2];
  logic            last;
  logic            rnd_owner;
  logic [1:0]      elig;
  logic [1:0]      grant;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [LAT-1:0]  tag_v;
  logic [LAT-1:0]  tag_o;
  logic [AW:0]     wr_ptr [2];
  logic [AW:0]     rd_ptr [2];
  logic [RESW-1:0] mem [2][DEPTH];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    elig  = '0;
    grant = '0;
    if (!reset) begin
      elig[0] = req_valid[0] && (cred[0] < CRED_MAX);
      elig[1] = req_valid[1] && (cred[1] < CRED_MAX);
    end
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = grant;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd_issue <= 1'b0;
      rnd_op    <= '0;
      rnd_owner <= 1'b0;
      last      <= 1'b1;
    end else begin
      rnd_issue <= |grant;
      if (|grant) begin
        rnd_op    <= grant[1] ? req_op[OPW +: OPW] : req_op[0 +: OPW];
        rnd_owner <= grant[1];
        last      <= grant[1];
      end
    end
  end

  // Stage 0 captures the op the rounder accepts this cycle; stage LAT-1 lines up with rnd_res.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v[0] <= rnd_issue;
      tag_o[0] <= rnd_owner;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_o[k] <= tag_o[k-1];
      end
    end
  end

  assign push = {tag_v[LAT-1] & tag_o[LAT-1], tag_v[LAT-1] & ~tag_o[LAT-1]};
  assign pop  = res_valid & res_ready;

  // Credit is held from grant until the consumer pops, so in-flight ops always have a slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) cred[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case ({grant[i], pop[i]})
          2'b10:   cred[i] <= cred[i] + CRED_ONE;
          2'b01:   cred[i] <= cred[i] - CRED_ONE;
          default: cred[i] <= cred[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
      end
    end
  end

  // NOTE: storage is not reset; the pointers define which entries are live and an
  // empty FIFO presents zero, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= rnd_res;
    end
  end

  always_comb begin
    res_valid = '0;
    res_data  = '0;
    for (int i = 0; i < 2; i++) begin
      res_valid[i] = (wr_ptr[i] != rd_ptr[i]);
      if (res_valid[i]) res_data[i*RESW +: RESW] = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

endmodule
